phys_reg_freelist: RTL and testbench
====================================

Name: phys_reg_freelist

Overview:
- Physical-register free-list manager for the 2-wide rename/commit pipeline.
- Rename side: allocates up to two destination pregs per cycle for instr1/instr2.
- Commit side: up to two retiring instructions per cycle return their p_old_rd to the pool.
- Holds the 64-bit freePool bitmap as state and publishes it to Rename.

Parameters:
- NUM_PREGS, 64, number of physical registers; one bitmap bit each, bit=1 means free.
- NUM_AREGS, 32, architectural registers; p0..p(NUM_AREGS-1) start mapped (identity RAT).
- PREG_W, 6, physical register index width (log2 NUM_PREGS).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- alloc_req1  in  1  instr1 needs a new rd (rd != x0).
- alloc_req2  in  1  instr2 needs a new rd (rd != x0).
- alloc_ready  out  1  pool can satisfy every asserted alloc_req this cycle.
- alloc_preg1  out  PREG_W  preg granted to instr1.
- alloc_preg2  out  PREG_W  preg granted to instr2.
- commit_valid1  in  1  retire slot 1 releases commit_old_preg1.
- commit_old_preg1  in  PREG_W  p_old_rd of retiring instr in slot 1.
- commit_valid2  in  1  retire slot 2 releases commit_old_preg2.
- commit_old_preg2  in  PREG_W  p_old_rd of retiring instr in slot 2.
- free_pool  out  NUM_PREGS  current freePool bitmap (registered).
- free_count  out  PREG_W+1  population count of free_pool.
- double_free_err  out  1  sticky: release of a preg that was already free.

Behaviour:
- Reset (rst_n=0 at a clk edge): free_pool = bits 0..31 clear, 32..63 set; free_count = 32; double_free_err = 0. Reset wins over all same-cycle requests; no allocation or release is applied that cycle.
- alloc_preg1/2 and alloc_ready are combinational from registered free_pool plus alloc_req1/2. free_pool and free_count change only at clock edges.
- Grant selection:
  - Lowest-index free bit L0; next-lowest L1.
  - req1 and req2 both set: preg1 = L0, preg2 = L1.
  - Only req1 set: preg1 = L0, preg2 = 0.
  - Only req2 set: preg2 = L0, preg1 = 0.
  - No request: both outputs 0.
- alloc_ready = (free_count >= req1 + req2). All-or-nothing: if alloc_ready=0, no bit is cleared and Rename must stall both instructions. Granted outputs are don't-care when not ready.
- Allocation commit: at the clock edge with alloc_ready=1, granted bits clear in the next free_pool.
- Release:
  - At the edge, commit_valid slots set bit commit_old_preg in the next free_pool.
  - p0 is never released; a commit of 0 is ignored and raises no error.
  - A preg released this cycle is not allocatable until the next cycle (no same-cycle bypass).
- Simultaneous allocate and release in one cycle: both applied. Next state = (free_pool & ~granted) | released. They never collide, because a granted bit was free and a released bit was allocated.
- Error conditions, each sets double_free_err (sticky until reset) and still leaves the bit set:
  - Releasing a preg whose bit is already 1.
  - Both commit slots naming the same nonzero preg in one cycle.
- free_count = popcount(free_pool), range 0..63 (p0 never free), registered alongside free_pool.
- Empty pool: free_count=0, so alloc_ready = ~(req1|req2). Releases still accepted.
- Full pool: at most 63 bits set; no special case.
- No internal pipeline. Latency is 0 cycles to grant (combinational) and 1 cycle for bitmap update.

Test Plan:
- Reset then idle -> free_pool=0xFFFF_FFFF_0000_0000, free_count=32, double_free_err=0, alloc_preg1/2=0.
- After reset, req1=req2=1 for one cycle -> alloc_preg1=32, alloc_preg2=33, alloc_ready=1; next cycle free_pool bits 32,33 clear, free_count=30.
- req2 only after reset -> alloc_preg2=32, alloc_preg1=0; next cycle only bit 32 cleared.
- Allocate all 32 free pregs (16 dual cycles) -> free_count=0. Then req1=1 -> alloc_ready=0 and state unchanged. In the same cycle commit_valid1=1, old_preg=5 -> next cycle free_count=1, bit 5 set; then req1 grants preg1=5.
- Same-cycle alloc+release at count 1 (free bit 40): req1=1, commit old_preg=7 -> grant 40 (not 7); next state bit 40 clear, bit 7 set, free_count=1.
- Double free: commit old_preg=50 while bit 50 free -> double_free_err=1 next cycle and stays 1. Commit slots 1 and 2 both =9 from clean reset -> error=1. Commit old_preg=0 -> no change, no error. Assert rst_n=0 mid-sequence -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/phys_reg_freelist.sv
// Physical-register free list for a 2-wide rename/commit pipeline.
// Keeps a registered bitmap with one bit per physical register (1 = free).
// Rename receives up to two grants per cycle. These are combinational from
// the registered bitmap. Commit returns up to two p_old_rd per cycle.
module phys_reg_freelist #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned PREG_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req1,
    input  logic                 alloc_req2,
    output logic                 alloc_ready,
    output logic [PREG_W-1:0]    alloc_preg1,
    output logic [PREG_W-1:0]    alloc_preg2,
    input  logic                 commit_valid1,
    input  logic [PREG_W-1:0]    commit_old_preg1,
    input  logic                 commit_valid2,
    input  logic [PREG_W-1:0]    commit_old_preg2,
    output logic [NUM_PREGS-1:0] free_pool,
    output logic [PREG_W:0]      free_count,
    output logic                 double_free_err
);

    // The identity RAT owns p0..p(NUM_AREGS-1). Every register above that starts free.
    localparam logic [NUM_PREGS-1:0] RST_POOL  = {NUM_PREGS{1'b1}} << NUM_AREGS;
    localparam logic [PREG_W:0]      RST_COUNT = (PREG_W+1)'(NUM_PREGS - NUM_AREGS);

    logic [NUM_PREGS-1:0] free_pool_q, free_pool_d;
    logic [PREG_W:0]      free_count_q, free_count_d;
    logic                 err_q, err_d;

    logic [PREG_W-1:0]    low0, low1;
    logic                 found0, found1;
    logic [NUM_PREGS-1:0] grant_mask;
    logic [NUM_PREGS-1:0] rel_mask;
    logic                 err_set;
    logic [PREG_W:0]      req_count;

    // Find the lowest and the second-lowest free register in the registered bitmap.
    always_comb begin
        low0   = '0;
        low1   = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            if (free_pool_q[i]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    low0   = PREG_W'(i);
                end else if (!found1) begin
                    found1 = 1'b1;
                    low1   = PREG_W'(i);
                end
            end
        end
    end

    // Assign grants to the requesting slots. The claimed bits are cleared only when every request fits.
    always_comb begin
        alloc_preg1 = '0;
        alloc_preg2 = '0;
        grant_mask  = '0;
        req_count   = (PREG_W+1)'(alloc_req1) + (PREG_W+1)'(alloc_req2);
        alloc_ready = (free_count_q >= req_count);
        if (alloc_req1) begin
            alloc_preg1 = low0;
            if (alloc_req2) begin
                alloc_preg2 = low1;
            end
        end else if (alloc_req2) begin
            alloc_preg2 = low0;
        end
        if (alloc_ready) begin
            if (alloc_req1 || alloc_req2) begin
                grant_mask[low0] = 1'b1;
            end
            if (alloc_req1 && alloc_req2) begin
                grant_mask[low1] = 1'b1;
            end
        end
    end

    // Release committed p_old_rd registers, never p0. Flag a release of a register that is already free.
    always_comb begin
        rel_mask = '0;
        err_set  = 1'b0;
        if (commit_valid1 && (commit_old_preg1 != '0)) begin
            rel_mask[commit_old_preg1] = 1'b1;
            if (free_pool_q[commit_old_preg1]) begin
                err_set = 1'b1;
            end
        end
        if (commit_valid2 && (commit_old_preg2 != '0)) begin
            rel_mask[commit_old_preg2] = 1'b1;
            if (free_pool_q[commit_old_preg2]) begin
                err_set = 1'b1;
            end
        end
        if (commit_valid1 && commit_valid2 && (commit_old_preg1 != '0) &&
            (commit_old_preg1 == commit_old_preg2)) begin
            err_set = 1'b1;
        end
    end

    // Next bitmap: allocate and release in the same cycle. Recount so free_count follows the bitmap exactly.
    always_comb begin
        free_pool_d  = (free_pool_q & ~grant_mask) | rel_mask;
        free_count_d = '0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            free_count_d = free_count_d + (PREG_W+1)'(free_pool_d[i]);
        end
        err_d = err_q | err_set;
    end

    // State register. Reset takes priority over any allocation or release in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_pool_q  <= RST_POOL;
            free_count_q <= RST_COUNT;
            err_q        <= 1'b0;
        end else begin
            free_pool_q  <= free_pool_d;
            free_count_q <= free_count_d;
            err_q        <= err_d;
        end
    end

    assign free_pool       = free_pool_q;
    assign free_count      = free_count_q;
    assign double_free_err = err_q;

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Scoreboard bench for phys_reg_freelist. The driver applies directed vectors
// and queues the hand-computed response for each one. The monitor takes one
// entry off the queue on every falling edge and compares it with the DUT.
module tb_phys_reg_freelist;

    localparam logic [63:0] RST = 64'hFFFF_FFFF_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req1, alloc_req2, alloc_ready;
    logic [5:0]  alloc_preg1, alloc_preg2;
    logic        commit_valid1, commit_valid2;
    logic [5:0]  commit_old_preg1, commit_old_preg2;
    logic [63:0] free_pool;
    logic [6:0]  free_count;
    logic        double_free_err;

    typedef struct {
        logic [63:0] pool;
        logic [6:0]  cnt;
        logic        err;
        logic        rdy;
        logic        chk_g;
        logic [5:0]  g1;
        logic [5:0]  g2;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;

    phys_reg_freelist #(.NUM_PREGS(64), .NUM_AREGS(32), .PREG_W(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_req1       (alloc_req1),
        .alloc_req2       (alloc_req2),
        .alloc_ready      (alloc_ready),
        .alloc_preg1      (alloc_preg1),
        .alloc_preg2      (alloc_preg2),
        .commit_valid1    (commit_valid1),
        .commit_old_preg1 (commit_old_preg1),
        .commit_valid2    (commit_valid2),
        .commit_old_preg2 (commit_old_preg2),
        .free_pool        (free_pool),
        .free_count       (free_count),
        .double_free_err  (double_free_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, got, want);
        end
    endtask

    // Drive one cycle of inputs after the rising edge and queue the response expected in that cycle.
    task automatic step(input logic rn, input logic q1, input logic q2,
                        input logic v1, input logic [5:0] p1,
                        input logic v2, input logic [5:0] p2,
                        input logic [63:0] pool, input logic [6:0] cnt,
                        input logic err, input logic rdy, input logic cg,
                        input logic [5:0] g1, input logic [5:0] g2);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rn;
        alloc_req1       = q1;
        alloc_req2       = q2;
        commit_valid1    = v1;
        commit_old_preg1 = p1;
        commit_valid2    = v2;
        commit_old_preg2 = p2;
        step_id++;
        e.pool = pool; e.cnt = cnt; e.err = err; e.rdy = rdy;
        e.chk_g = cg; e.g1 = g1; e.g2 = g2; e.id = step_id;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation on the falling edge after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("free_pool",  e.id, free_pool,                 e.pool);
                chk("free_count", e.id, {57'd0, free_count},       {57'd0, e.cnt});
                chk("dfree_err",  e.id, {63'd0, double_free_err},  {63'd0, e.err});
                chk("ready",      e.id, {63'd0, alloc_ready},      {63'd0, e.rdy});
                if (e.chk_g) begin
                    chk("preg1", e.id, {58'd0, alloc_preg1}, {58'd0, e.g1});
                    chk("preg2", e.id, {58'd0, alloc_preg2}, {58'd0, e.g2});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alloc_req1 = 1'b0; alloc_req2 = 1'b0;
        commit_valid1 = 1'b0; commit_old_preg1 = '0;
        commit_valid2 = 1'b0; commit_old_preg2 = '0;
        @(posedge clk);

        // reset state, dual grant, then the bitmap update
        step(1,0,0, 0,0, 0,0, RST, 32, 0, 1, 1, 0, 0);
        step(1,1,1, 0,0, 0,0, RST, 32, 0, 1, 1, 32, 33);
        step(1,0,0, 0,0, 0,0, 64'hFFFF_FFFC_0000_0000, 30, 0, 1, 1, 0, 0);
        // reset, then req2 only
        step(0,0,0, 0,0, 0,0, 64'hFFFF_FFFC_0000_0000, 30, 0, 1, 1, 0, 0);
        step(1,0,1, 0,0, 0,0, RST, 32, 0, 1, 1, 0, 32);
        step(0,0,0, 0,0, 0,0, 64'hFFFF_FFFE_0000_0000, 31, 0, 1, 1, 0, 0);
        // drain the pool with 16 dual allocations
        for (int k = 0; k < 16; k++) begin
            step(1,1,1, 0,0, 0,0, RST << (2*k), 7'(32 - 2*k), 0, 1, 1, 6'(32 + 2*k), 6'(33 + 2*k));
        end
        // empty pool: stall, release 5 in the same cycle, then grant 5
        step(1,1,0, 1,5, 0,0, 64'h0, 0, 0, 0, 0, 0, 0);
        step(1,1,0, 0,0, 0,0, 64'h20, 1, 0, 1, 1, 5, 0);
        step(1,0,0, 1,40, 0,0, 64'h0, 0, 0, 1, 1, 0, 0);
        // count 1 with bit 40 free: grant 40 while 7 is released, and 7 is not bypassed
        step(1,1,0, 1,7, 0,0, 64'h1 << 40, 1, 0, 1, 1, 40, 0);
        step(1,1,1, 0,0, 0,0, 64'h80, 1, 0, 0, 0, 0, 0);
        step(1,0,1, 0,0, 0,0, 64'h80, 1, 0, 1, 1, 0, 7);
        step(1,0,0, 1,7, 0,0, 64'h0, 0, 0, 1, 1, 0, 0);
        // double free of 7, which is sticky through the reset cycle
        step(1,0,0, 1,7, 0,0, 64'h80, 1, 0, 1, 1, 0, 0);
        step(0,0,0, 0,0, 0,0, 64'h80, 1, 1, 1, 1, 0, 0);
        // double free of 50 from reset
        step(1,0,0, 1,50, 0,0, RST, 32, 0, 1, 1, 0, 0);
        step(1,0,0, 0,0, 0,0, RST, 32, 1, 1, 1, 0, 0);
        step(0,0,0, 0,0, 0,0, RST, 32, 1, 1, 1, 0, 0);
        // both slots release 9 in one cycle
        step(1,0,0, 1,9, 1,9, RST, 32, 0, 1, 1, 0, 0);
        step(0,0,0, 0,0, 0,0, RST | (64'h1 << 9), 33, 1, 1, 1, 0, 0);
        // releases of p0 are ignored, then two distinct releases and reallocation of them
        step(1,0,0, 1,0, 1,0, RST, 32, 0, 1, 1, 0, 0);
        step(1,0,0, 1,3, 1,4, RST, 32, 0, 1, 1, 0, 0);
        step(1,1,1, 0,0, 0,0, RST | 64'h18, 34, 0, 1, 1, 3, 4);
        // reset wins over same-cycle allocation and release
        step(0,1,1, 1,9, 0,0, RST, 32, 0, 1, 1, 32, 33);
        step(1,0,0, 0,0, 0,0, RST, 32, 0, 1, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
